// File: rtl/pwm_speed_pkg.sv
// Shared types and constants for the PWM speed control stage.
// Optional feature macro: PWM_SPEED_PRESET_EN (adds preset_valid/preset_val on the top).
package pwm_speed_pkg;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP_UP = 2'd1,
        RAMP_DN = 2'd2
    } state_t;

    // Direction the ramp must move to bring speed onto goal; IDLE when already there.
    function automatic state_t ramp_dir(input logic [SPEED_W-1:0] goal,
                                        input logic [SPEED_W-1:0] speed);
        state_t dir;
        if (goal > speed) begin
            dir = RAMP_UP;
        end else if (goal < speed) begin
            dir = RAMP_DN;
        end else begin
            dir = IDLE;
        end
        return dir;
    endfunction

endpackage

// File: rtl/pwm_speed_ctrl_btn_debounce.sv
// Raw push-button front end: 2-FF synchronizer, stability debouncer and a
// one-cycle press pulse on the debounced rising edge (release is silent).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_speed_ctrl.sv
// PWM speed control stage: two debounced buttons set a saturating 3-bit target,
// and speed_out ramps toward it one code per RAMP_TICKS cycles. Disabling ramps
// speed to 0 before enable_out drops.
// Optional feature macro: PWM_SPEED_PRESET_EN adds preset_valid/preset_val, which
// load the target directly and take priority over button presses.
module pwm_speed_ctrl
    import pwm_speed_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int RAMP_TICKS      = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_in,
    input  logic               btn_up,
    input  logic               btn_dn,
    output logic [SPEED_W-1:0] speed_out,
    output logic               enable_out,
    output logic [SPEED_W-1:0] target,
    output logic               busy
`ifdef PWM_SPEED_PRESET_EN
    ,
    input  logic               preset_valid,
    input  logic [SPEED_W-1:0] preset_val
`endif
);

    localparam int TICK_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RAMP_TICKS - 1);

    logic               up_press;
    logic               dn_press;
    logic [SPEED_W-1:0] target_next;
    logic [SPEED_W-1:0] goal;

    // Ramp FSM state; kept as a named signal so checkers can bind to it.
    state_t             state;
    state_t             state_next;
    logic [SPEED_W-1:0] speed_next;
    logic [TICK_W-1:0]  tick_cnt;
    logic [TICK_W-1:0]  tick_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .press (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_dn),
        .press (dn_press)
    );

    // Next target: preset wins, simultaneous presses cancel, both ends saturate.
    always_comb begin
        target_next = target;
`ifdef PWM_SPEED_PRESET_EN
        if (preset_valid) begin
            target_next = preset_val;
        end else
`endif
        if (up_press && !dn_press && target != SPEED_MAX) begin
            target_next = target + SPEED_W'(1);
        end else if (dn_press && !up_press && target != '0) begin
            target_next = target - SPEED_W'(1);
        end
    end

    // Hold the target speed; it tracks the buttons even while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
        end else begin
            target <= target_next;
        end
    end

    assign goal = enable_in ? target : '0;

    // Ramp decision: reverse or stop immediately, otherwise step on terminal tick.
    always_comb begin
        state_next = state;
        speed_next = speed_out;
        tick_next  = tick_cnt;
        case (state)
            IDLE: begin
                state_next = ramp_dir(goal, speed_out);
                tick_next  = '0;
            end
            RAMP_UP, RAMP_DN: begin
                if (ramp_dir(goal, speed_out) != state) begin
                    state_next = ramp_dir(goal, speed_out);
                    tick_next  = '0;
                end else if (tick_cnt == TICK_LAST) begin
                    speed_next = (state == RAMP_UP) ? speed_out + SPEED_W'(1)
                                                    : speed_out - SPEED_W'(1);
                    state_next = ramp_dir(goal, speed_next);
                    tick_next  = '0;
                end else begin
                    tick_next = tick_cnt + TICK_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                tick_next  = '0;
            end
        endcase
    end

    // Ramp registers; busy is registered alongside state so it mirrors it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            speed_out <= '0;
            tick_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            speed_out <= speed_next;
            tick_cnt  <= tick_next;
            busy      <= (state_next != IDLE);
        end
    end

    // Keep the PWM stage enabled until the ramp has brought speed back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_out <= 1'b0;
        end else begin
            enable_out <= enable_in || (speed_out != '0);
        end
    end

endmodule

// File: tb/tb_pwm_speed_ctrl.sv
// Bench for pwm_speed_ctrl with DEBOUNCE_CYCLES=4, RAMP_TICKS=8.
// Every speed_out step is predicted as {edge number, code} in exp_q and
// matched by a monitor sampling #1 after each rising edge.
// Optional feature macro: PWM_SPEED_PRESET_EN enables the preset scenario.
module tb_pwm_speed_ctrl;

    localparam int DEB = 4;
    localparam int RT  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_in;
    logic       btn_up;
    logic       btn_dn;
    logic [2:0] speed_out;
    logic       enable_out;
    logic [2:0] target;
    logic       busy;
`ifdef PWM_SPEED_PRESET_EN
    logic       preset_valid;
    logic [2:0] preset_val;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [34:0] exp_q[$];
    logic [2:0]  prev_speed;

    pwm_speed_ctrl #(.DEBOUNCE_CYCLES(DEB), .RAMP_TICKS(RT)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_in  (enable_in),
        .btn_up     (btn_up),
        .btn_dn     (btn_dn),
        .speed_out  (speed_out),
        .enable_out (enable_out),
        .target     (target),
        .busy       (busy)
`ifdef PWM_SPEED_PRESET_EN
        ,
        .preset_valid (preset_valid),
        .preset_val   (preset_val)
`endif
    );

    // Clock and edge counter: after rising edge k, cyc == k.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: each speed_out change must match the next expected step.
    always begin : monitor
        logic [34:0] e;
        @(posedge clk);
        #1;
        if (rst) begin
            prev_speed = speed_out;
        end else if (speed_out !== prev_speed) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL step_unexpected: got speed=%0d at cycle %0d, expected no change",
                         speed_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({cyc[31:0], speed_out} !== e) begin
                    errors++;
                    $display("FAIL step: got speed=%0d at cycle %0d, expected speed=%0d at cycle %0d",
                             speed_out, cyc, e[2:0], e[34:3]);
                end
            end
            prev_speed = speed_out;
        end
    end

    task automatic expect_step(input int c, input int s);
        exp_q.push_back({c[31:0], s[2:0]});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Clean press: 4 cycles high, 4 cycles low; next press may start on return.
    task automatic press(input logic up, input logic dn);
        btn_up = up;
        btn_dn = dn;
        repeat (DEB) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (DEB) @(negedge clk);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        enable_in = 1'b0;
        btn_up    = 1'b0;
        btn_dn    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (speed_out !== 3'd0) begin errors++; $display("FAIL reset_speed: got %0d, expected 0", speed_out); end
        checks++; if (target !== 3'd0) begin errors++; $display("FAIL reset_target: got %0d, expected 0", target); end
        checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0b, expected 0", enable_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
    endtask

    task automatic test_ramp_up;
        int n;
        enable_in = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (enable_out !== 1'b1) begin errors++; $display("FAIL en_zero_target: got %0b, expected 1", enable_out); end
        checks++; if (busy !== 1'b0 || speed_out !== 3'd0) begin errors++; $display("FAIL idle_zero_target: got busy=%0b speed=%0d, expected 0/0", busy, speed_out); end
        n = cyc;
        expect_step(n + 16, 1);
        expect_step(n + 24, 2);
        expect_step(n + 32, 3);
        press(1'b1, 1'b0);
        checks++; if (target !== 3'd1) begin errors++; $display("FAIL up_target1: got %0d, expected 1", target); end
        press(1'b1, 1'b0);
        checks++; if (target !== 3'd2) begin errors++; $display("FAIL up_target2: got %0d, expected 2", target); end
        press(1'b1, 1'b0);
        checks++; if (target !== 3'd3) begin errors++; $display("FAIL up_target3: got %0d, expected 3", target); end
        wait_until(n + 31);
        checks++; if (busy !== 1'b1 || speed_out !== 3'd2) begin errors++; $display("FAIL ramp_mid: got busy=%0b speed=%0d, expected 1/2", busy, speed_out); end
        wait_until(n + 32);
        checks++; if (busy !== 1'b0 || speed_out !== 3'd3) begin errors++; $display("FAIL ramp_done: got busy=%0b speed=%0d, expected 0/3", busy, speed_out); end
        wait_until(n + 34);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ramp_up_pending: got %0d steps outstanding, expected 0", exp_q.size()); end
    endtask

    task automatic test_bounce;
        int b;
        b = cyc;
        expect_step(b + 24, 4);
        for (int i = 0; i < 5; i++) begin
            btn_up = ~i[0];
            repeat (2) @(negedge clk);
        end
        btn_up = 1'b1;
        wait_until(b + 14);
        checks++; if (target !== 3'd3) begin errors++; $display("FAIL bounce_early: got %0d, expected 3", target); end
        wait_until(b + 15);
        checks++; if (target !== 3'd4) begin errors++; $display("FAIL bounce_accept: got %0d, expected 4", target); end
        wait_until(b + 20);
        btn_up = 1'b0;
        wait_until(b + 32);
        checks++; if (target !== 3'd4 || speed_out !== 3'd4 || busy !== 1'b0) begin
            errors++; $display("FAIL bounce_settle: got target=%0d speed=%0d busy=%0b, expected 4/4/0", target, speed_out, busy);
        end
    endtask

    task automatic test_saturate_high;
        int p;
        p = cyc;
        expect_step(p + 16, 5);
        expect_step(p + 24, 6);
        expect_step(p + 32, 7);
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        checks++; if (target !== 3'd7) begin errors++; $display("FAIL sat_reach7: got %0d, expected 7", target); end
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0);
        checks++; if (target !== 3'd7 || speed_out !== 3'd7) begin
            errors++; $display("FAIL sat_hold7: got target=%0d speed=%0d, expected 7/7", target, speed_out);
        end
    endtask

    task automatic test_disable_ramp;
        int q;
        int d;
        q = cyc;
        expect_step(q + 16, 6);
        expect_step(q + 24, 5);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        wait_until(q + 24);
        checks++; if (target !== 3'd5 || busy !== 1'b0) begin errors++; $display("FAIL dn_to5: got target=%0d busy=%0b, expected 5/0", target, busy); end
        @(negedge clk);
        d = cyc;
        enable_in = 1'b0;
        for (int i = 1; i <= 5; i++) expect_step(d + 1 + RT * i, 5 - i);
        wait_until(d + 1);
        checks++; if (enable_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL dis_start: got en=%0b busy=%0b, expected 1/1", enable_out, busy); end
        wait_until(d + 41);
        checks++; if (enable_out !== 1'b1 || speed_out !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL dis_zero: got en=%0b speed=%0d busy=%0b, expected 1/0/0", enable_out, speed_out, busy);
        end
        wait_until(d + 42);
        checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL dis_en_drop: got %0b, expected 0", enable_out); end
        checks++; if (target !== 3'd5) begin errors++; $display("FAIL dis_target_kept: got %0d, expected 5", target); end
    endtask

    task automatic test_low_limits;
        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        checks++; if (target !== 3'd0) begin errors++; $display("FAIL dn_to0: got %0d, expected 0", target); end
        press(1'b0, 1'b1);
        checks++; if (target !== 3'd0) begin errors++; $display("FAIL sat_hold0: got %0d, expected 0", target); end
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        checks++; if (target !== 3'd1) begin errors++; $display("FAIL both_cancel: got %0d, expected 1", target); end
        for (int i = 0; i < 5; i++) press(1'b1, 1'b0);
        checks++; if (target !== 3'd6 || speed_out !== 3'd0 || enable_out !== 1'b0) begin
            errors++; $display("FAIL disabled_up: got target=%0d speed=%0d en=%0b, expected 6/0/0", target, speed_out, enable_out);
        end
    endtask

    task automatic test_reversal_and_reset;
        int e;
        e = cyc;
        enable_in = 1'b1;
        expect_step(e + 9, 1);
        expect_step(e + 17, 2);
        expect_step(e + 28, 1);
        wait_until(e + 19);
        enable_in = 1'b0;
        wait_until(e + 20);
        checks++; if (busy !== 1'b1 || speed_out !== 3'd2) begin errors++; $display("FAIL rev_turn: got busy=%0b speed=%0d, expected 1/2", busy, speed_out); end
        wait_until(e + 27);
        checks++; if (speed_out !== 3'd2) begin errors++; $display("FAIL rev_hold: got %0d, expected 2", speed_out); end
        wait_until(e + 30);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rev_pending: got %0d steps outstanding, expected 0", exp_q.size()); end
        rst = 1'b1;
        #1;
        checks++; if (speed_out !== 3'd0 || target !== 3'd0 || enable_out !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got speed=%0d target=%0d en=%0b busy=%0b, expected all 0", speed_out, target, enable_out, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef PWM_SPEED_PRESET_EN
    task automatic test_preset;
        int n;
        n = cyc;
        btn_up = 1'b1;
        wait_until(n + 4);
        btn_up = 1'b0;
        wait_until(n + 6);
        preset_valid = 1'b1;
        preset_val   = 3'd6;
        wait_until(n + 7);
        preset_valid = 1'b0;
        checks++; if (target !== 3'd6) begin errors++; $display("FAIL preset_load: got %0d, expected 6", target); end
        wait_until(n + 10);
        checks++; if (target !== 3'd6) begin errors++; $display("FAIL preset_hold: got %0d, expected 6", target); end
    endtask
`endif

    initial begin
`ifdef PWM_SPEED_PRESET_EN
        preset_valid = 1'b0;
        preset_val   = 3'd0;
`endif
        test_reset();
        test_ramp_up();
        test_bounce();
        test_saturate_high();
        test_disable_ramp();
        test_low_limits();
        test_reversal_and_reset();
`ifdef PWM_SPEED_PRESET_EN
        test_preset();
`endif
        repeat (4) @(negedge clk);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d steps outstanding, expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
